reg_bank_arbiter: RTL and testbench

//  Shares a bank of NUM_REGS enable-gated WIDTH-bit registers between NUM_REQ requesters.

---
 rtl/reg_bank_arbiter.sv | 132 +++++++++++++
 tb/tb_reg_bank_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_arbiter.sv
// Round-robin share of a small register bank between NUM_REQ requesters.
// Fixed 3 cycles per transaction (accept, execute, respond); losers hold req_valid until req_ready.
module reg_bank_arbiter #(
  parameter int WIDTH    = 8,
  parameter int NUM_REGS = 4,
  parameter int NUM_REQ  = 2,
  localparam int AW      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  input  logic [NUM_REQ-1:0]       req_we_i,
  input  logic [NUM_REQ*AW-1:0]    req_addr_i,
  input  logic [NUM_REQ*WIDTH-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  output logic [NUM_REQ-1:0]       rsp_valid_o,
  output logic [WIDTH-1:0]         rsp_rdata_o,
  output logic                     rsp_err_o,
  output logic                     busy_o
);

  localparam int RW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic [RW-1:0]    win;
    logic             we;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] wdata;
  } txn_t;

  state_t           state_q, state_d;
  txn_t             txn_q;
  logic [RW-1:0]    rr_ptr_q;
  logic [RW-1:0]    win_idx;
  logic             any_vld;
  logic [WIDTH-1:0] bank_q [NUM_REGS];
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [WIDTH-1:0] rsp_rdata_q;
  logic             rsp_err_q;
  logic             in_range;
  logic [WIDTH-1:0] rd_dat;

  // First valid requester at or above rr_ptr, wrapping back to 0.
  always_comb begin
    win_idx = '0;
    any_vld = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!any_vld && req_valid_i[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
        any_vld = 1'b1;
        win_idx = RW'((int'(rr_ptr_q) + k) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    req_ready_o = '0;
    case (state_q)
      IDLE: begin
        if (any_vld) begin
          req_ready_o[win_idx] = 1'b1;
          state_d              = EXEC;
        end
      end
      EXEC:    state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_range = 1'b0;
    rd_dat   = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (txn_q.addr == AW'(r)) begin
        in_range = 1'b1;
        rd_dat   = bank_q[r];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      txn_q       <= '0;
      rr_ptr_q    <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      for (int r = 0; r < NUM_REGS; r++) bank_q[r] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_vld) begin
            txn_q <= '{win:   win_idx,
                       we:    req_we_i[win_idx],
                       addr:  req_addr_i[int'(win_idx)*AW +: AW],
                       wdata: req_wdata_i[int'(win_idx)*WIDTH +: WIDTH]};
          end
        end
        EXEC: begin
          rsp_valid_q[txn_q.win] <= 1'b1;
          rsp_err_q              <= !in_range;
          // A write echoes the stored value; out-of-range returns zero.
          rsp_rdata_q <= !in_range ? '0 : (txn_q.we ? txn_q.wdata : rd_dat);
          if (txn_q.we) begin
            for (int r = 0; r < NUM_REGS; r++) begin
              if (txn_q.addr == AW'(r)) bank_q[r] <= txn_q.wdata;
            end
          end
        end
        RESP: begin
          rsp_valid_q <= '0;
          rr_ptr_q    <= (txn_q.win == RW'(NUM_REQ - 1)) ? '0 : txn_q.win + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed bench for reg_bank_arbiter; NUM_REGS=3 so address 3 exercises the error path.
module tb_reg_bank_arbiter;
  localparam int WIDTH    = 8;
  localparam int NUM_REGS = 3;
  localparam int NUM_REQ  = 2;
  localparam int AW       = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_we;
  logic [NUM_REQ*AW-1:0]    req_addr;
  logic [NUM_REQ*WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]         rsp_rdata;
  logic                     rsp_err;
  logic                     busy;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  reg_bank_arbiter #(.WIDTH(WIDTH), .NUM_REGS(NUM_REGS), .NUM_REQ(NUM_REQ)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_we_i    (req_we),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .req_ready_o (req_ready),
    .rsp_valid_o (rsp_valid),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .busy_o      (busy)
  );

  typedef struct {
    int               r;
    logic             we;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rdata;
    logic             err;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NUM_REQ-1:0] oh(input int r);
    logic [NUM_REQ-1:0] v;
    v    = '0;
    v[r] = 1'b1;
    return v;
  endfunction

  task automatic drive(input int r, input logic v, input logic we,
                       input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    req_valid[r]              = v;
    req_we[r]                 = we;
    req_addr[r*AW +: AW]      = a;
    req_wdata[r*WIDTH +: WIDTH] = d;
  endtask

  // Called just after a negedge with the DUT idle; returns just after the negedge of the next IDLE cycle.
  task automatic txn(input vec_t v, input string tag);
    drive(v.r, 1'b1, v.we, v.addr, v.wdata);
    #1;
    chk({tag, " ready"}, 32'(req_ready), 32'(oh(v.r)));
    chk({tag, " idle busy"}, 32'(busy), 32'd0);
    @(negedge clk);
    drive(v.r, 1'b0, 1'b0, '0, '0);
    #1;
    chk({tag, " exec busy"}, 32'(busy), 32'd1);
    chk({tag, " exec rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, " exec ready"}, 32'(req_ready), 32'd0);
    @(negedge clk);
    #1;
    chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'(oh(v.r)));
    chk({tag, " rdata"}, 32'(rsp_rdata), 32'(v.rdata));
    chk({tag, " err"}, 32'(rsp_err), 32'(v.err));
    @(negedge clk);
    #1;
    chk({tag, " back idle"}, 32'(busy), 32'd0);
    chk({tag, " rsp_valid drop"}, 32'(rsp_valid), 32'd0);
    chk({tag, " rdata hold"}, 32'(rsp_rdata), 32'(v.rdata));
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst ready", 32'(req_ready), 32'd0);
    chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst rdata", 32'(rsp_rdata), 32'd0);
    chk("rst err", 32'(rsp_err), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    logic [NUM_REQ-1:0] exp_v;

    vecs[0] = '{0, 1'b1, 2'd2, 8'hA5, 8'hA5, 1'b0};
    vecs[1] = '{0, 1'b0, 2'd2, 8'h00, 8'hA5, 1'b0};
    vecs[2] = '{1, 1'b1, 2'd3, 8'hFF, 8'h00, 1'b1};
    vecs[3] = '{1, 1'b0, 2'd3, 8'h00, 8'h00, 1'b1};
    vecs[4] = '{0, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0};
    vecs[5] = '{1, 1'b0, 2'd2, 8'h00, 8'hA5, 1'b0};
    vecs[6] = '{1, 1'b1, 2'd0, 8'h5A, 8'h5A, 1'b0};
    vecs[7] = '{0, 1'b0, 2'd0, 8'h00, 8'h5A, 1'b0};
    vecs[8] = '{0, 1'b1, 2'd1, 8'h77, 8'h77, 1'b0};
    vecs[9] = '{1, 1'b0, 2'd1, 8'h00, 8'h77, 1'b0};

    do_reset();
    for (int i = 0; i < 10; i++) txn(vecs[i], $sformatf("vec%0d", i));

    // Both requesters held valid: grants alternate every 3 cycles starting at 0.
    do_reset();
    drive(0, 1'b1, 1'b0, 2'd0, 8'h00);
    drive(1, 1'b1, 1'b0, 2'd3, 8'h00);
    for (int c = 0; c < 12; c++) begin
      if (c > 0) begin
        @(negedge clk);
        #1;
      end else begin
        #1;
      end
      exp_v = (c % 3 == 0) ? oh((c / 3) % 2) : '0;
      chk($sformatf("rr ready c%0d", c), 32'(req_ready), 32'(exp_v));
      exp_v = (c % 3 == 2) ? oh((c / 3) % 2) : '0;
      chk($sformatf("rr rsp_valid c%0d", c), 32'(rsp_valid), 32'(exp_v));
      if (c % 3 == 2) chk($sformatf("rr err c%0d", c), 32'(rsp_err), 32'((c / 3) % 2));
    end
    @(negedge clk);
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    #1;
    chk("rr stop ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    #1;
    chk("rr stop busy", 32'(busy), 32'd0);

    // Write by req0 then queued read by req1 of the same address sees the new value.
    drive(0, 1'b1, 1'b1, 2'd1, 8'h3C);
    drive(1, 1'b1, 1'b0, 2'd1, 8'h00);
    #1;
    chk("wr-rd ready0", 32'(req_ready), 32'(oh(0)));
    @(negedge clk);
    drive(0, 1'b0, 1'b0, '0, '0);
    #1;
    chk("wr-rd exec ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    #1;
    chk("wr-rd rsp0", 32'(rsp_valid), 32'(oh(0)));
    chk("wr-rd rdata0", 32'(rsp_rdata), 32'h3C);
    @(negedge clk);
    #1;
    chk("wr-rd ready1", 32'(req_ready), 32'(oh(1)));
    @(negedge clk);
    drive(1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    #1;
    chk("wr-rd rsp1", 32'(rsp_valid), 32'(oh(1)));
    chk("wr-rd rdata1", 32'(rsp_rdata), 32'h3C);
    chk("wr-rd err1", 32'(rsp_err), 32'd0);
    @(negedge clk);
    #1;

    // Reset during EXEC of a write aborts it.
    drive(0, 1'b1, 1'b1, 2'd1, 8'h99);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, '0, '0);
    #1;
    rst = 1'b1;
    #1;
    chk("exec-rst busy", 32'(busy), 32'd0);
    chk("exec-rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("exec-rst rdata", 32'(rsp_rdata), 32'd0);
    @(negedge clk);
    #1;
    chk("exec-rst hold rsp_valid", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    v = '{1, 1'b0, 2'd1, 8'h00, 8'h00, 1'b0};
    txn(v, "post-exec-rst rd1");

    // Reset during RESP of a read: response is squashed, bank cleared.
    v = '{0, 1'b1, 2'd2, 8'h42, 8'h42, 1'b0};
    txn(v, "pre-resp-rst wr2");
    drive(0, 1'b1, 1'b0, 2'd2, 8'h00);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("resp-rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("resp-rst busy", 32'(busy), 32'd0);
    chk("resp-rst rdata", 32'(rsp_rdata), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("resp-rst quiet c%0d", c), 32'(rsp_valid), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    #1;
    v = '{0, 1'b0, 2'd2, 8'h00, 8'h00, 1'b0};
    txn(v, "post-resp-rst rd2");
    v = '{1, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0};
    txn(v, "post-resp-rst rd0");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
